// File: rtl/fence_flush_ctrl_pkg.sv
// Fence request types, sequencer states and small decode helpers
// shared by the fence/flush controller and its users.
package fence_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        FENCE      = 2'd0,
        FENCE_I    = 2'd1,
        SFENCE_VMA = 2'd2
    } fence_type_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_DFLUSH = 3'd2,
        S_IFLUSH = 3'd3,
        S_TFLUSH = 3'd4,
        S_DONE   = 3'd5
    } fence_state_e;

    // Encoding 3 is reserved and behaves as a plain FENCE.
    function automatic fence_type_e norm_type(input logic [1:0] t);
        return (t == 2'd1) ? FENCE_I : (t == 2'd2) ? SFENCE_VMA : FENCE;
    endfunction

    function automatic fence_state_e step_after_d(input fence_type_e t);
        return (t == FENCE_I) ? S_IFLUSH : (t == SFENCE_VMA) ? S_TFLUSH : S_DONE;
    endfunction

endpackage

// File: rtl/fence_flush_ctrl_wdog.sv
// Saturating ack-wait watchdog: clears on clr_i, counts while en_i,
// flags expiry on the LIMIT-th enabled cycle. LIMIT=0 disables it.
module fence_wdog_cnt #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire_o = (LIMIT > 0) && en_i && (r_cnt == LAST);

endmodule

// File: rtl/fence_flush_ctrl.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: drain stores, optional D-cache
// flush, I-cache or TLB flush, then a done pulse to commit.
module fence_flush_ctrl
    import fence_flush_ctrl_pkg::*;
#(
    parameter bit FLUSH_ON_FENCE = 1'b0,
    parameter bit INVAL_ON_FLUSH = 1'b0,
    parameter bit DCACHE_WB      = 1'b0,
    parameter int MAX_OUT_STORES = 7,
    parameter int WDOG_CYCLES    = 1024,
    localparam int CW            = $clog2(MAX_OUT_STORES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    input  logic [1:0]    req_type_i,
    output logic          req_ready_o,
    input  logic          st_buf_empty_i,
    input  logic [CW-1:0] st_out_cnt_i,
    output logic          dcache_flush_o,
    output logic          dcache_inval_o,
    input  logic          dcache_ack_i,
    output logic          icache_flush_o,
    output logic          tlb_flush_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          wdog_err_o
);
    fence_state_e r_state;
    fence_state_e w_next;
    fence_type_e  r_type;

    logic r_ready, r_busy, r_dflush, r_inval;
    logic r_iflush, r_tflush, r_done, r_err;
    logic w_accept, w_clean, w_need_d, w_ack, w_expire;

    assign w_accept = req_valid_i && r_ready;
    assign w_clean  = st_buf_empty_i && (st_out_cnt_i == '0);
    assign w_need_d = ((r_type == FENCE) && FLUSH_ON_FENCE)
                   || ((r_type == FENCE_I) && DCACHE_WB);
    assign w_ack    = dcache_ack_i && (r_state == S_DFLUSH);

    fence_wdog_cnt #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   ((r_state != S_DFLUSH) && (w_next == S_DFLUSH)),
        .en_i    (r_state == S_DFLUSH),
        .expire_o(w_expire)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DRAIN;
            S_DRAIN:  if (w_clean)
                          w_next = w_need_d ? S_DFLUSH : step_after_d(r_type);
            S_DFLUSH: if (w_ack || w_expire) w_next = step_after_d(r_type);
            S_IFLUSH: w_next = S_DONE;
            S_TFLUSH: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so none follow inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_type   <= FENCE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_dflush <= 1'b0;
            r_inval  <= 1'b0;
            r_iflush <= 1'b0;
            r_tflush <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (w_accept) r_type <= norm_type(req_type_i);
            r_ready  <= (w_next == S_IDLE);
            r_busy   <= (w_next != S_IDLE);
            r_dflush <= (w_next == S_DFLUSH);
            r_inval  <= INVAL_ON_FLUSH && (w_next == S_DFLUSH);
            r_iflush <= (w_next == S_IFLUSH);
            r_tflush <= (w_next == S_TFLUSH);
            r_done   <= (w_next == S_DONE);
            if (w_expire && !w_ack) r_err <= 1'b1;
        end
    end

    assign req_ready_o    = r_ready;
    assign busy_o         = r_busy;
    assign dcache_flush_o = r_dflush;
    assign dcache_inval_o = r_inval;
    assign icache_flush_o = r_iflush;
    assign tlb_flush_o    = r_tflush;
    assign done_o         = r_done;
    assign wdog_err_o     = r_err;

endmodule

// File: tb/tb_fence_flush_ctrl.sv
// Randomized bench for fence_flush_ctrl against a transaction-level
// timeline model (FENCE.I flushes D$ via DCACHE_WB, watchdog of 16).
module tb_fence_flush_ctrl;
    localparam int CW = 3;
    localparam int WD = 16;
    localparam int P_IDLE = 0, P_DR = 1, P_DF = 2, P_IF = 3, P_TF = 4, P_DN = 5;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic [1:0] req_type;
    logic req_ready;
    logic st_empty;
    logic [CW-1:0] st_cnt;
    logic dflush, dinval, dack, iflush, tflush, busy, done, werr;

    int total = 0;
    int bad = 0;
    bit m_err = 1'b0;

    typedef struct {
        int ph;
        int k;
        bit e;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    fence_flush_ctrl #(
        .FLUSH_ON_FENCE(1'b0),
        .INVAL_ON_FLUSH(1'b1),
        .DCACHE_WB(1'b1),
        .MAX_OUT_STORES(7),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_type_i(req_type),
        .req_ready_o(req_ready),
        .st_buf_empty_i(st_empty),
        .st_out_cnt_i(st_cnt),
        .dcache_flush_o(dflush),
        .dcache_inval_o(dinval),
        .dcache_ack_i(dack),
        .icache_flush_o(iflush),
        .tlb_flush_o(tflush),
        .busy_o(busy),
        .done_o(done),
        .wdog_err_o(werr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {req_ready, busy, dflush, dinval, iflush, tflush, done, werr};
    endfunction

    function automatic logic [7:0] ev(input int ph, input bit e);
        return {ph == P_IDLE, ph != P_IDLE, ph == P_DF, ph == P_DF,
                ph == P_IF, ph == P_TF, ph == P_DN, e};
    endfunction

    task automatic noise();
        st_empty = 1'($urandom_range(0, 1));
        st_cnt   = 3'($urandom_range(0, 7));
        dack     = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle", 32'(obs()), 32'(ev(P_IDLE, m_err)));
        req_valid = 1'b0;
        req_type  = 2'($urandom_range(0, 3));
        noise();
    endtask

    // a in 1..WD: ack in that DFLUSH cycle; anything else: no ack.
    task automatic run_txn(input int ty, input int d, input int a,
                           input bit dec);
        int tn;
        int n;
        bit to;
        tn = (ty == 3) ? 0 : ty;
        to = !(a >= 1 && a <= WD);
        q.delete();
        for (int k = 0; k <= d; k++) q.push_back('{P_DR, k, m_err});
        if (tn == 1) begin
            n = to ? WD : a;
            for (int j = 1; j <= n; j++) q.push_back('{P_DF, j, m_err});
            if (to) m_err = 1'b1;
            q.push_back('{P_IF, 0, m_err});
        end
        if (tn == 2) q.push_back('{P_TF, 0, m_err});
        q.push_back('{P_DN, 0, m_err});

        @(negedge clk);
        chk("accept", 32'(obs()), 32'(ev(P_IDLE, q[0].e)));
        req_valid = 1'b1;
        req_type  = 2'(ty);
        noise();

        foreach (q[i]) begin
            @(negedge clk);
            chk($sformatf("ty%0d ph%0d k%0d", ty, q[i].ph, q[i].k),
                32'(obs()), 32'(ev(q[i].ph, q[i].e)));
            req_valid = 1'b1;
            req_type  = 2'($urandom_range(0, 3));
            noise();
            if (q[i].ph == P_DR) begin
                if (dec) begin
                    st_empty = 1'b1;
                    st_cnt   = 3'(d - q[i].k);
                end else if (q[i].k == d) begin
                    st_empty = 1'b1;
                    st_cnt   = '0;
                end else begin
                    case ($urandom_range(0, 2))
                        0: begin st_empty = 1'b0; st_cnt = '0; end
                        1: begin st_empty = 1'b1; st_cnt = 3'($urandom_range(1, 7)); end
                        default: begin st_empty = 1'b0; st_cnt = 3'($urandom_range(1, 7)); end
                    endcase
                end
            end else if (q[i].ph == P_DF) begin
                dack = (q[i].k == a);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_type = 2'd0;
        st_empty = 1'b1;
        st_cnt = '0;
        dack = 1'b0;
        @(negedge clk);
        chk("reset", 32'(obs()), 32'(ev(P_IDLE, 1'b0)));
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 0, 0, 1'b0);
        run_txn(0, 3, 0, 1'b1);
        run_txn(1, 0, 5, 1'b0);
        run_txn(2, 2, 0, 1'b0);
        run_txn(1, 1, WD, 1'b0);
        run_txn(3, 1, 0, 1'b0);
        run_txn(1, 0, 0, 1'b0);
        run_txn(0, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, WD + 2)), 1'b0);
        end

        // Asynchronous reset in the middle of a D-cache flush.
        @(negedge clk);
        req_valid = 1'b1;
        req_type = 2'd1;
        st_empty = 1'b1;
        st_cnt = '0;
        dack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_dflush", 32'(dflush), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_err = 1'b0;
        chk("rst_async", 32'(obs()), 32'(ev(P_IDLE, 1'b0)));
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        run_txn(2, 0, 0, 1'b0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
